mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port data RAM between NUM_CORES cores using round-robin arbitration. Each core uses its request/wren/address/writedata/response/readdata handshake. The arbiter sits between the core array and the on-chip RAM. It serialises accesses, one transaction in flight at a time, and returns a one-cycle response pulse to the granted core.

Parameters:
WIDTH, 32, data and core-address width
NUM_CORES, 4, number of requesting cores (power of two, at least 2)
IDX_WIDTH, 2, log2(NUM_CORES); width of the grant index
ADDR_WIDTH, 16, RAM address width; core address is truncated to its low ADDR_WIDTH bits
MEM_LATENCY, 1, clock edges from first address presentation to valid mem_readdata (at least 1)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
core_request  in  NUM_CORES  per-core request, held high until that core's response
core_wren  in  NUM_CORES  per-core write enable (1 = write, 0 = read)
core_address  in  NUM_CORES*WIDTH  flattened addresses; core i occupies [i*WIDTH +: WIDTH]
core_writedata  in  NUM_CORES*WIDTH  flattened write data, same packing
core_response  out  NUM_CORES  one-hot, one-cycle completion pulse
core_readdata  out  WIDTH  shared read-data bus; valid while the matching response bit is high
mem_address  out  ADDR_WIDTH  RAM address
mem_wren  out  1  RAM write strobe
mem_writedata  out  WIDTH  RAM write data
mem_readdata  in  WIDTH  RAM read data
busy  out  1  high when state is not IDLE
grant_index  out  IDX_WIDTH  index of the current or most recent granted core

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - state = IDLE
  - core_response = 0, mem_wren = 0, busy = 0
  - core_readdata = 0, mem_address = 0, mem_writedata = 0
  - grant_index = 0
  - rr_last = NUM_CORES-1, so core 0 wins the first tie
- Reset mid-transaction abandons the access. No response is issued, and mem_wren drops on the reset edge.
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - If any core_request bit is high, pick the first requester scanning rr_last+1, rr_last+2, … modulo NUM_CORES.
  - On that edge, register the grant index g and the request fields:
    - address: low ADDR_WIDTH bits
    - writedata
    - wren
  - Clear the counter cnt=0 and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS, write (wren_q=1):
  - Lasts exactly one cycle.
  - mem_address=addr_q, mem_writedata=wd_q, mem_wren=1.
  - Then go to RESP.
- ACCESS, read (wren_q=0):
  - mem_wren=0 and mem_address=addr_q, held stable for MEM_LATENCY+1 cycles.
  - cnt increments each cycle.
  - When cnt==MEM_LATENCY, capture mem_readdata into core_readdata and go to RESP.
- RESP:
  - core_response[g]=1 for exactly one cycle; all other response bits are 0.
  - On the exit edge, set rr_last=g and go to IDLE.
  - core_readdata holds its value until the next read capture. Writes leave it unchanged.
- Latency, with a request first sampled in IDLE cycle T:
  - write: response during T+2
  - read: response during T+MEM_LATENCY+2 (T+3 at default)
- Back-to-back operation:
  - A core deasserts request on the edge that ends its response cycle.
  - IDLE therefore never re-grants a completed request, and no dead cycle beyond IDLE is required.
  - Maximum throughput is one write every 3 cycles.
- Request fields are sampled only at grant. Later changes to that core's inputs, or its request dropping, do not affect the in-flight access, which completes and still pulses a response.
- Requests arriving during ACCESS or RESP wait and are arbitrated in the next IDLE cycle.
- Fairness: a continuously requesting core is granted within NUM_CORES transactions.
- mem_wren is asserted only in write ACCESS and is never high in IDLE or RESP.
- Address truncation drops the upper bits silently; no error is flagged.

Test Plan:
- Single write: core 1 writes 0xDEADBEEF to 0x0010 at T → mem_wren=1 with mem_address=0x0010 during T+1; core_response=4'b0010 during T+2; busy falls at T+3.
- Single read (MEM_LATENCY=1): RAM holds 0x12345678 at 0x0020, core 2 reads → core_response=4'b0100 during T+3 with core_readdata=0x12345678; core_readdata holds after the pulse.
- All four cores request simultaneously after reset, each re-requesting immediately after its response → grant order 0,1,2,3,0,1; exactly one response bit high per transaction.
- Core 3 requests continuously while core 0 re-requests after every response → strict alternation 0,3,0,3; core 3 is never starved.
- Reset asserted during read ACCESS of core 1 → next cycle state IDLE, busy=0, no response pulse; the next grant goes to core 0 when cores 0 and 1 both request.
- Address 0xABCD1234 with ADDR_WIDTH=16 → mem_address=0x1234; core_writedata changed after the grant → mem_writedata keeps the value sampled at the grant.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Core-array and RAM-side bus of the shared-RAM arbiter.
// master: requesting cores plus the RAM model; slave: the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [NUM_CORES-1:0]       core_request;
  logic [NUM_CORES-1:0]       core_wren;
  logic [NUM_CORES*WIDTH-1:0] core_address;
  logic [NUM_CORES*WIDTH-1:0] core_writedata;
  logic [NUM_CORES-1:0]       core_response;
  logic [WIDTH-1:0]           core_readdata;
  logic [ADDR_WIDTH-1:0]      mem_address;
  logic                       mem_wren;
  logic [WIDTH-1:0]           mem_writedata;
  logic [WIDTH-1:0]           mem_readdata;
  logic                       busy;
  logic [IDX_WIDTH-1:0]       grant_index;

  modport master (
    output core_request, core_wren, core_address, core_writedata, mem_readdata,
    input  core_response, core_readdata, mem_address, mem_wren, mem_writedata,
           busy, grant_index
  );

  modport slave (
    input  core_request, core_wren, core_address, core_writedata, mem_readdata,
    output core_response, core_readdata, mem_address, mem_wren, mem_writedata,
           busy, grant_index
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_CORES cores,
// one transaction in flight, one-cycle response pulse to the granted core.
module mem_arbiter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned IDX_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   rr_last_q, rr_last_d;
  logic [IDX_WIDTH-1:0]   grant_q, grant_d;
  logic                   wren_q, wren_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CORES-1:0]   resp_q, resp_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]       wd_q, wd_d;
  logic                   mem_wren_q, mem_wren_d;
  logic                   busy_q, busy_d;

  logic [IDX_WIDTH-1:0]   pick;
  logic [IDX_WIDTH-1:0]   cand;
  logic                   found;

  // First requester after rr_last; index arithmetic wraps since NUM_CORES is 2^IDX_WIDTH.
  always_comb begin
    pick  = rr_last_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CORES; i++) begin
      cand = rr_last_q + IDX_WIDTH'(i);
      if (!found && bus.core_request[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    grant_d    = grant_q;
    wren_d     = wren_q;
    cnt_d      = cnt_q;
    resp_d     = '0;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    mem_wren_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          addr_d     = bus.core_address[32'(pick) * WIDTH +: ADDR_WIDTH];
          wd_d       = bus.core_writedata[32'(pick) * WIDTH +: WIDTH];
          wren_d     = bus.core_wren[pick];
          mem_wren_d = bus.core_wren[pick];
          cnt_d      = '0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (wren_q) begin
          resp_d[grant_q] = 1'b1;
          state_d         = RESP;
        end else if (cnt_q == CNT_W'(MEM_LATENCY)) begin
          rdata_d         = bus.mem_readdata;
          resp_d[grant_q] = 1'b1;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rr_last_d = grant_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_last_q  <= IDX_WIDTH'(NUM_CORES - 1);
      grant_q    <= '0;
      wren_q     <= 1'b0;
      cnt_q      <= '0;
      resp_q     <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      mem_wren_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      grant_q    <= grant_d;
      wren_q     <= wren_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      mem_wren_q <= mem_wren_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.core_response = resp_q;
  assign bus.core_readdata = rdata_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_writedata = wd_q;
  assign bus.mem_wren      = mem_wren_q;
  assign bus.busy          = busy_q;
  assign bus.grant_index   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-core transactions plus
// hand-written arbitration, reset and throughput sequences.
module tb_mem_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned NC = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] last_rd;
  logic [31:0] ram [0:65535];
  int   got[$];
  int   got_cyc[$];

  mem_arbiter_if #(.WIDTH(W), .NUM_CORES(NC), .IDX_WIDTH(2), .ADDR_WIDTH(16)) bus ();

  mem_arbiter #(
    .WIDTH(W), .NUM_CORES(NC), .IDX_WIDTH(2), .ADDR_WIDTH(16), .MEM_LATENCY(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency RAM model.
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_writedata;
    bus.mem_readdata <= ram[bus.mem_address];
  end

  typedef struct {
    int          core;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.core_request = '0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] onehot;
    onehot = 4'(1) << v.core;
    @(negedge clk);
    bus.core_request[v.core]             = 1'b1;
    bus.core_wren[v.core]                = v.wren;
    bus.core_address[v.core*W +: W]      = v.addr;
    bus.core_writedata[v.core*W +: W]    = v.wdata;
    @(negedge clk);
    chk("access_busy", 64'(bus.busy), 64'(1));
    chk("access_addr", 64'(bus.mem_address), 64'(v.exp_addr));
    chk("access_wren", 64'(bus.mem_wren), 64'(v.wren));
    chk("access_grant", 64'(bus.grant_index), 64'(v.core));
    if (v.wren) chk("access_wdata", 64'(bus.mem_writedata), 64'(v.wdata));
    bus.core_address[v.core*W +: W]   = ~v.addr;
    bus.core_writedata[v.core*W +: W] = ~v.wdata;
    if (v.wren) begin
      @(negedge clk);
      chk("wr_resp", 64'(bus.core_response), 64'(onehot));
      chk("wr_resp_wren_low", 64'(bus.mem_wren), 64'(0));
      chk("wr_wdata_held", 64'(bus.mem_writedata), 64'(v.wdata));
      chk("wr_rdata_unchanged", 64'(bus.core_readdata), 64'(last_rd));
      bus.core_request[v.core] = 1'b0;
    end else begin
      @(negedge clk);
      chk("rd_wait_resp", 64'(bus.core_response), 64'(0));
      chk("rd_addr_held", 64'(bus.mem_address), 64'(v.exp_addr));
      chk("rd_wren_low", 64'(bus.mem_wren), 64'(0));
      @(negedge clk);
      chk("rd_resp", 64'(bus.core_response), 64'(onehot));
      chk("rd_data", 64'(bus.core_readdata), 64'(v.exp_rdata));
      last_rd = v.exp_rdata;
      bus.core_request[v.core] = 1'b0;
    end
    @(negedge clk);
    chk("end_busy", 64'(bus.busy), 64'(0));
    chk("end_resp", 64'(bus.core_response), 64'(0));
    chk("end_rdata_hold", 64'(bus.core_readdata), 64'(last_rd));
  endtask

  // Gather n response pulses in order; bounded so a stuck DUT still reaches the summary.
  task automatic collect(input int n);
    int cyc;
    cyc = 0;
    got.delete();
    got_cyc.delete();
    while (got.size() < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      chk("resp_onehot", 64'($countones(bus.core_response) <= 1), 64'(1));
      for (int i = 0; i < NC; i++) begin
        if (bus.core_response[i]) begin
          got.push_back(i);
          got_cyc.push_back(cyc);
        end
      end
    end
    chk("resp_count", 64'(got.size()), 64'(n));
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (bus.busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_idle", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int exp_rr [6];
    int exp_alt [4];
    checks = 0;
    errors = 0;
    last_rd = '0;
    exp_rr  = '{0, 1, 2, 3, 0, 1};
    exp_alt = '{0, 3, 0, 3};

    vecs[0] = '{core: 1, wren: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, exp_addr: 16'h0010, exp_rdata: 32'h0};
    vecs[1] = '{core: 2, wren: 1'b0, addr: 32'h0000_0020, wdata: 32'h0,         exp_addr: 16'h0020, exp_rdata: 32'h1234_5678};
    vecs[2] = '{core: 0, wren: 1'b1, addr: 32'hABCD_1234, wdata: 32'hCAFE_F00D, exp_addr: 16'h1234, exp_rdata: 32'h0};
    vecs[3] = '{core: 3, wren: 1'b0, addr: 32'h0000_1234, wdata: 32'h0,         exp_addr: 16'h1234, exp_rdata: 32'hCAFE_F00D};
    vecs[4] = '{core: 1, wren: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,         exp_addr: 16'h0010, exp_rdata: 32'hDEAD_BEEF};
    vecs[5] = '{core: 2, wren: 1'b1, addr: 32'hFFFF_FFFF, wdata: 32'h5A5A_5A5A, exp_addr: 16'hFFFF, exp_rdata: 32'h0};
    vecs[6] = '{core: 3, wren: 1'b0, addr: 32'h0001_FFFF, wdata: 32'h0,         exp_addr: 16'hFFFF, exp_rdata: 32'h5A5A_5A5A};

    ram[16'h0020] = 32'h1234_5678;
    rst_n = 1'b0;
    bus.core_request   = '0;
    bus.core_wren      = '0;
    bus.core_address   = '0;
    bus.core_writedata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_resp", 64'(bus.core_response), 64'(0));
    chk("rst_mem_wren", 64'(bus.mem_wren), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_address), 64'(0));
    chk("rst_mem_wdata", 64'(bus.mem_writedata), 64'(0));
    chk("rst_rdata", 64'(bus.core_readdata), 64'(0));
    chk("rst_grant", 64'(bus.grant_index), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // All cores request at once and keep requesting: rotation 0,1,2,3,0,1 at one write per 3 cycles.
    do_reset();
    bus.core_wren    = '1;
    bus.core_address = '0;
    bus.core_request = 4'hF;
    collect(6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk("rr_order", 64'(got[i]), 64'(exp_rr[i]));
    for (int i = 1; i < 6; i++)
      if (i < got_cyc.size()) chk("write_spacing", 64'(got_cyc[i] - got_cyc[i-1]), 64'(3));
    bus.core_request = '0;
    wait_idle();

    // Cores 0 and 3 contend continuously: strict alternation.
    do_reset();
    bus.core_request = 4'b1001;
    collect(4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("alt_order", 64'(got[i]), 64'(exp_alt[i]));
    bus.core_request = '0;
    wait_idle();

    // Reset during core 1's read access abandons it; core 0 then wins the tie.
    @(negedge clk);
    bus.core_wren[1]       = 1'b0;
    bus.core_address[W +: W] = 32'h0000_0020;
    bus.core_request[1]    = 1'b1;
    @(negedge clk);
    chk("midrst_busy_before", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_resp", 64'(bus.core_response), 64'(0));
    chk("midrst_wren", 64'(bus.mem_wren), 64'(0));
    rst_n = 1'b1;
    bus.core_wren[0]    = 1'b1;
    bus.core_request[0] = 1'b1;
    @(negedge clk);
    chk("midrst_grant", 64'(bus.grant_index), 64'(0));
    collect(1);
    if (got.size() > 0) chk("midrst_first_resp", 64'(got[0]), 64'(0));
    bus.core_request = '0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
